// File: rtl/if_prefetch_queue_if.sv
// Fetch front-end bundle: EX redirect, instruction-memory request/response,
// and the valid/ready handshake into IF/ID.
interface if_prefetch_queue_if #(
   parameter int XLEN = 32
);
   logic            redirect_i;
   logic [XLEN-1:0] redirect_addr_i;
   logic            req_o;
   logic [XLEN-1:0] req_addr_o;
   logic            gnt_i;
   logic            rvalid_i;
   logic [XLEN-1:0] rdata_i;
   logic            inst_valid_o;
   logic            inst_ready_i;
   logic [XLEN-1:0] inst_o;
   logic [XLEN-1:0] inst_addr_o;

   // master: the prefetch queue itself
   modport master (
      input  redirect_i, redirect_addr_i, gnt_i, rvalid_i, rdata_i, inst_ready_i,
      output req_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o
   );

   // slave: memory + IF/ID + EX side
   modport slave (
      output redirect_i, redirect_addr_i, gnt_i, rvalid_i, rdata_i, inst_ready_i,
      input  req_o, req_addr_o, inst_valid_o, inst_o, inst_addr_o
   );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch queue: credit-limited fetch requests to a variable-latency
// memory, DEPTH-entry FIFO of {pc, inst}, and stale-response discard on redirect.
module if_prefetch_queue #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input logic                 clk,
   input logic                 rst,
   if_prefetch_queue_if.master bus
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] data;
   } entry_t;

   entry_t          fifo_q [DEPTH];
   logic [PW-1:0]   rd_ptr, wr_ptr;
   logic [CW-1:0]   count, outstanding, discard;
   logic [XLEN-1:0] fetch_pc, resp_pc, target;
   logic [CW:0]     credits_used;
   logic            grant, resp, push, pop;

   assign target       = {bus.redirect_addr_i[XLEN-1:2], 2'b00};
   assign credits_used = {1'b0, count} + {1'b0, outstanding};

   // A request is only issued when a FIFO slot is reserved for its response,
   // so a kept response can always be pushed.
   assign bus.req_o      = !rst && !bus.redirect_i && (credits_used < (CW+1)'(DEPTH));
   assign bus.req_addr_o = fetch_pc;
   assign grant          = bus.req_o && bus.gnt_i;

   // A response with nothing outstanding is a protocol violation and is ignored.
   assign resp = bus.rvalid_i && (outstanding != '0);
   assign push = resp && (discard == '0) && !bus.redirect_i;
   assign pop  = bus.inst_valid_o && bus.inst_ready_i && !bus.redirect_i;

   assign bus.inst_valid_o = (count != '0);
   assign bus.inst_o       = fifo_q[rd_ptr].data;
   assign bus.inst_addr_o  = fifo_q[rd_ptr].addr;

   always_ff @(posedge clk) begin
      if (rst) begin
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         outstanding <= '0;
         discard     <= '0;
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
      end else begin
         outstanding <= outstanding + CW'(grant) - CW'(resp);
         if (bus.redirect_i) begin
            // Everything still in flight belongs to the old path; this
            // cycle's response (if any) is dropped directly.
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= target;
            resp_pc  <= target;
            discard  <= outstanding - CW'(resp);
         end else begin
            if (grant)
               fetch_pc <= fetch_pc + XLEN'(4);
            if (resp && (discard != '0))
               discard <= discard - CW'(1);
            if (push) begin
               resp_pc <= resp_pc + XLEN'(4);
               wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop)
               rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_q[wr_ptr] <= '{addr: resp_pc, data: bus.rdata_i};
   end
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Bench for if_prefetch_queue: queue-based fetch model checked every cycle,
// plus hand-computed expectations for reset, stall, redirect and PC wrap.
module tb_if_prefetch_queue;
   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   if_prefetch_queue_if #(.XLEN(XLEN)) bus ();
   if_prefetch_queue_if #(.XLEN(XLEN)) busw ();

   if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );
   if_prefetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_w (
      .clk(clk), .rst(rst), .bus(busw)
   );

   typedef struct { logic [31:0] addr; logic [31:0] data; } fent_t;
   typedef struct { logic [31:0] addr; bit stale; } inf_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   fent_t       fq[$];     // instructions that must be visible, head first
   inf_t        infl[$];   // granted fetches not yet answered, grant order
   mreq_t       mq[$];     // memory's pending responses
   logic [31:0] m_pc;
   logic [31:0] sb_next;
   int          total = 0, bad = 0;
   int          cyc, lat;
   bit          spurious;
   bit          w_pend;
   logic [31:0] w_addr;

   bit          obs_v[0:63], obs_req[0:63], w_v[0:63];
   logic [31:0] obs_a[0:63], obs_d[0:63], obs_ra[0:63], w_a[0:63], w_d[0:63];

   function automatic logic [31:0] memf(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0F0F_1234;
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   function automatic int first_valid(int from);
      for (int c = from; c < 64; c++)
         if (obs_v[c]) return c;
      return -1;
   endfunction

   // One clock: drive memory responses, compare at negedge, advance the model.
   task automatic cycle();
      bit          exp_req, exp_v, resp, pop, grant, memresp, dgrant;
      inf_t        e;
      memresp = (mq.size() > 0) && (mq[0].due <= cyc);
      bus.rvalid_i  = memresp || spurious;
      bus.rdata_i   = memresp ? memf(mq[0].addr) : 32'hDEAD_BEEF;
      busw.rvalid_i = w_pend;
      busw.rdata_i  = memf(w_addr);
      @(negedge clk);
      exp_req = !rst && !bus.redirect_i && (fq.size() + infl.size() < DEPTH);
      exp_v   = (fq.size() != 0);
      chk("req", 32'(bus.req_o), 32'(exp_req));
      if (exp_req) chk("req_addr", bus.req_addr_o, m_pc);
      chk("valid", 32'(bus.inst_valid_o), 32'(exp_v));
      if (exp_v) begin
         chk("inst_addr", bus.inst_addr_o, fq[0].addr);
         chk("inst", bus.inst_o, fq[0].data);
      end
      if (cyc < 64) begin
         obs_v[cyc] = bus.inst_valid_o;   obs_a[cyc]  = bus.inst_addr_o;
         obs_d[cyc] = bus.inst_o;         obs_req[cyc] = bus.req_o;
         obs_ra[cyc] = bus.req_addr_o;    w_v[cyc] = busw.inst_valid_o;
         w_a[cyc] = busw.inst_addr_o;     w_d[cyc] = busw.inst_o;
      end
      // Consumed stream must be sequential, restarting at each redirect target.
      if (!rst) begin
         if (bus.redirect_i)
            sb_next = bus.redirect_addr_i & ~32'h3;
         else if (bus.inst_valid_o && bus.inst_ready_i) begin
            chk("seq", bus.inst_addr_o, sb_next);
            sb_next += 4;
         end
      end
      if (rst) begin
         fq.delete(); infl.delete(); mq.delete();
         m_pc = 32'h0; sb_next = 32'h0; w_pend = 1'b0;
      end else begin
         resp   = bus.rvalid_i && (infl.size() > 0);
         pop    = exp_v && bus.inst_ready_i;
         grant  = exp_req && bus.gnt_i;
         dgrant = bus.req_o && bus.gnt_i;
         if (memresp) void'(mq.pop_front());
         if (dgrant) mq.push_back('{addr: bus.req_addr_o, due: cyc + lat});
         if (bus.redirect_i) begin
            fq.delete();
            foreach (infl[i]) infl[i].stale = 1'b1;
            if (resp) void'(infl.pop_front());
            m_pc = bus.redirect_addr_i & ~32'h3;
         end else begin
            if (pop) void'(fq.pop_front());
            if (resp) begin
               e = infl.pop_front();
               if (!e.stale) fq.push_back('{addr: e.addr, data: bus.rdata_i});
            end
            if (grant) begin
               infl.push_back('{addr: m_pc, stale: 1'b0});
               m_pc += 4;
            end
         end
         w_pend = busw.req_o && busw.gnt_i;
         w_addr = busw.req_addr_o;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      bus.redirect_i = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 64; i++) begin
         obs_v[i] = 1'b0; obs_req[i] = 1'b0; w_v[i] = 1'b0;
      end
   endtask

   initial begin
      int n, fc;
      bus.redirect_i = 1'b0; bus.redirect_addr_i = '0; bus.gnt_i = 1'b0;
      bus.inst_ready_i = 1'b0; bus.rvalid_i = 1'b0; bus.rdata_i = '0;
      busw.redirect_i = 1'b0; busw.redirect_addr_i = '0; busw.gnt_i = 1'b1;
      busw.inst_ready_i = 1'b1; busw.rvalid_i = 1'b0; busw.rdata_i = '0;
      spurious = 1'b0; lat = 1; w_pend = 1'b0; w_addr = '0; cyc = 0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // Streaming with 1-cycle memory; second instance shows the PC wrap.
      do_reset();
      bus.gnt_i = 1'b1; bus.inst_ready_i = 1'b1; lat = 1;
      repeat (12) cycle();
      chk("p1_req0", 32'(obs_req[0]), 32'd1);
      chk("p1_reqaddr0", obs_ra[0], 32'h0);
      chk("p1_v1", 32'(obs_v[1]), 32'd0);
      for (int k = 0; k < 6; k++) begin
         chk("p1_v", 32'(obs_v[2+k]), 32'd1);
         chk("p1_addr", obs_a[2+k], 32'(4*k));
      end
      chk("p1_data2", obs_d[2], memf(32'h0));
      chk("wrap_a2", w_a[2], 32'hFFFF_FFF8);
      chk("wrap_a3", w_a[3], 32'hFFFF_FFFC);
      chk("wrap_a4", w_a[4], 32'h0000_0000);
      chk("wrap_v4", 32'(w_v[4]), 32'd1);
      chk("wrap_d4", w_d[4], memf(32'h0));

      // Stall for 10 cycles: only DEPTH grants, head held, then drain in order.
      do_reset();
      bus.gnt_i = 1'b1; bus.inst_ready_i = 1'b0; lat = 1;
      repeat (10) cycle();
      n = 0;
      for (int c = 0; c < 10; c++) if (obs_req[c]) n++;
      chk("p2_grants", 32'(n), 32'd4);
      chk("p2_req_low", 32'(obs_req[9]), 32'd0);
      chk("p2_head", obs_a[9], 32'h0);
      bus.inst_ready_i = 1'b1;
      repeat (8) cycle();
      for (int k = 0; k < 5; k++) begin
         chk("p2_rel_v", 32'(obs_v[10+k]), 32'd1);
         chk("p2_rel_addr", obs_a[10+k], 32'(4*k));
      end

      // 3-cycle memory, redirect with 3 outstanding (one returning that cycle).
      do_reset();
      bus.gnt_i = 1'b1; bus.inst_ready_i = 1'b1; lat = 3;
      bus.redirect_addr_i = 32'h0000_0100;
      for (int c = 0; c < 16; c++) begin
         bus.redirect_i = (c == 3);
         cycle();
      end
      bus.redirect_i = 1'b0;
      chk("p3_req_redir", 32'(obs_req[3]), 32'd0);
      chk("p3_v_after", 32'(obs_v[4]), 32'd0);
      chk("p3_req_after", 32'(obs_req[4]), 32'd1);
      chk("p3_reqaddr_after", obs_ra[4], 32'h100);
      fc = first_valid(4);
      chk("p3_first_cyc", 32'(fc), 32'd8);
      if (fc >= 0) begin
         chk("p3_first_addr", obs_a[fc], 32'h100);
         chk("p3_first_data", obs_d[fc], memf(32'h100));
      end

      // Redirect coinciding with a response and a pop; misaligned target.
      do_reset();
      bus.gnt_i = 1'b1; bus.inst_ready_i = 1'b1; lat = 2;
      bus.redirect_addr_i = 32'h0000_0203;
      for (int c = 0; c < 14; c++) begin
         bus.redirect_i = (c == 6);
         cycle();
      end
      bus.redirect_i = 1'b0;
      chk("p4_pop_v", 32'(obs_v[6]), 32'd1);
      chk("p4_pop_addr", obs_a[6], 32'hC);
      chk("p4_empty", 32'(obs_v[7]), 32'd0);
      chk("p4_reqaddr", obs_ra[7], 32'h200);
      fc = first_valid(7);
      chk("p4_first_cyc", 32'(fc), 32'd10);
      if (fc >= 0) chk("p4_first_addr", obs_a[fc], 32'h200);

      // Spurious response with nothing outstanding must be ignored.
      do_reset();
      bus.gnt_i = 1'b0; bus.inst_ready_i = 1'b1; lat = 1; spurious = 1'b1;
      cycle();
      spurious = 1'b0; bus.gnt_i = 1'b1;
      repeat (6) cycle();
      chk("p5_v3", 32'(obs_v[3]), 32'd1);
      chk("p5_addr3", obs_a[3], 32'h0);

      // Mixed grant/ready/latency patterns with several redirects.
      do_reset();
      for (int c = 0; c < 200; c++) begin
         bus.gnt_i        = ((c * 7) % 5) != 0;
         bus.inst_ready_i = ((c * 3) % 7) < 5;
         lat              = 1 + (c % 3);
         bus.redirect_i   = (c == 23) || (c == 57) || (c == 58) || (c == 101) || (c == 150);
         bus.redirect_addr_i = 32'h0000_1000 + 32'(c * 8) + 32'h1 + 32'(c % 2);
         cycle();
      end
      bus.redirect_i = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
